// File: rtl/rf_wr_arbiter_pkg.sv
// Shared register-file geometry and arbitration types for the writeback arbiter.
package rf_wr_arbiter_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int REG_DATA_W   = 32;
    localparam int RF_REG_NUM   = 32;
    localparam int STARVE_CNT_W = 3;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // Which of the two secondary requesters wins the next tie
    typedef enum logic {
        RR_DIV = 1'b0,
        RR_DBG = 1'b1
    } rr_fav_e;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, divider and
// debug share leftover slots round-robin, with a scoreboard of pending divider results.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int REG_NUM      = rf_wr_arbiter_pkg::RF_REG_NUM,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ex_wr_en,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic [REG_DATA_W-1:0] ex_wr_data,

    input  logic                  div_issue,
    input  logic [REG_ADDR_W-1:0] div_issue_addr,

    input  logic                  div_valid,
    input  logic [REG_ADDR_W-1:0] div_addr,
    input  logic [REG_DATA_W-1:0] div_data,
    output logic                  div_ready,

    input  logic                  dbg_valid,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [REG_DATA_W-1:0] dbg_data,
    output logic                  dbg_ready,

    input  logic [REG_ADDR_W-1:0] rd1_addr,
    input  logic [REG_ADDR_W-1:0] rd2_addr,
    output logic                  rd1_busy,
    output logic                  rd2_busy,

    output logic                  hold_ex,

    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [REG_DATA_W-1:0] rf_wr_data
);

    rr_fav_e                   r_rr_fav;
    logic [STARVE_CNT_W-1:0]   r_starve_cnt;
    logic                      r_hold_ex;
    logic [REG_NUM-1:0]        r_pending;

    logic                      w_ex_req;
    logic                      w_div_gnt;
    logic                      w_dbg_gnt;
    logic [STARVE_CNT_W-1:0]   w_starve_cnt_next;
    logic                      w_hold_ex_next;
    logic [REG_NUM-1:0]        w_pending_next;

    function automatic logic addr_tracked(input logic [REG_ADDR_W-1:0] a);
        return (a != ZERO_REG) && (int'(a) < REG_NUM);
    endfunction

    assign w_ex_req = ex_wr_en && (ex_wr_addr != ZERO_REG);

    always_comb begin
        w_div_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (!rst && !w_ex_req) begin
            if (div_valid && (!dbg_valid || r_rr_fav == RR_DIV)) begin
                w_div_gnt = 1'b1;
            end else if (dbg_valid) begin
                w_dbg_gnt = 1'b1;
            end
        end
    end

    assign div_ready = w_div_gnt;
    assign dbg_ready = w_dbg_gnt;

    // Granted writes to x0 still consume the handshake but never reach the file
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        if (!rst && w_ex_req) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = ex_wr_addr;
            rf_wr_data = ex_wr_data;
        end else if (w_div_gnt && div_addr != ZERO_REG) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = div_addr;
            rf_wr_data = div_data;
        end else if (w_dbg_gnt && dbg_addr != ZERO_REG) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = dbg_addr;
            rf_wr_data = dbg_data;
        end
    end

    always_comb begin
        w_starve_cnt_next = r_starve_cnt;
        if (w_div_gnt || w_dbg_gnt || !(div_valid || dbg_valid)) begin
            w_starve_cnt_next = '0;
        end else if (r_starve_cnt != '1) begin
            w_starve_cnt_next = r_starve_cnt + 1'b1;
        end
        w_hold_ex_next = int'(w_starve_cnt_next) >= STARVE_LIMIT;
    end

    // Clear before set so a same-cycle issue to the retiring address stays pending
    always_comb begin
        w_pending_next = r_pending;
        if (w_div_gnt && addr_tracked(div_addr)) begin
            w_pending_next[div_addr] = 1'b0;
        end
        if (div_issue && addr_tracked(div_issue_addr)) begin
            w_pending_next[div_issue_addr] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    // A result being written this cycle is forwarded, so it no longer blocks decode
    assign rd1_busy = addr_tracked(rd1_addr) && r_pending[rd1_addr]
                      && !(w_div_gnt && div_addr == rd1_addr);
    assign rd2_busy = addr_tracked(rd2_addr) && r_pending[rd2_addr]
                      && !(w_div_gnt && div_addr == rd2_addr);

    assign hold_ex = r_hold_ex;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_fav     <= RR_DIV;
            r_starve_cnt <= '0;
            r_hold_ex    <= 1'b0;
            r_pending    <= '0;
        end else begin
            if (w_div_gnt) begin
                r_rr_fav <= RR_DBG;
            end else if (w_dbg_gnt) begin
                r_rr_fav <= RR_DIV;
            end
            r_starve_cnt <= w_starve_cnt_next;
            r_hold_ex    <= w_hold_ex_next;
            r_pending    <= w_pending_next;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_rf_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        ex_wr_en;
    logic [4:0]  ex_wr_addr;
    logic [31:0] ex_wr_data;
    logic        div_issue;
    logic [4:0]  div_issue_addr;
    logic        div_valid;
    logic [4:0]  div_addr;
    logic [31:0] div_data;
    logic        div_ready;
    logic        dbg_valid;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_ready;
    logic [4:0]  rd1_addr;
    logic [4:0]  rd2_addr;
    logic        rd1_busy;
    logic        rd2_busy;
    logic        hold_ex;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    int n_checks = 0;
    int n_errors = 0;

    rf_wr_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ex_wr_en       (ex_wr_en),
        .ex_wr_addr     (ex_wr_addr),
        .ex_wr_data     (ex_wr_data),
        .div_issue      (div_issue),
        .div_issue_addr (div_issue_addr),
        .div_valid      (div_valid),
        .div_addr       (div_addr),
        .div_data       (div_data),
        .div_ready      (div_ready),
        .dbg_valid      (dbg_valid),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data),
        .dbg_ready      (dbg_ready),
        .rd1_addr       (rd1_addr),
        .rd2_addr       (rd2_addr),
        .rd1_busy       (rd1_busy),
        .rd2_busy       (rd2_busy),
        .hold_ex        (hold_ex),
        .rf_wr_en       (rf_wr_en),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wr_data     (rf_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: who is favoured, how long secondaries have waited,
    // whether the pipeline is being held, and which registers await the divider.
    bit          m_fav_dbg;
    int          m_wait;
    bit          m_hold;
    bit          m_pend [32];

    logic        e_div_rdy, e_dbg_rdy, e_wen, e_busy1, e_busy2, e_hold;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    task automatic model_reset();
        m_fav_dbg = 1'b0;
        m_wait    = 0;
        m_hold    = 1'b0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    task automatic model_eval();
        bit ex;
        ex = ex_wr_en && (ex_wr_addr != 5'd0);
        e_div_rdy = 1'b0; e_dbg_rdy = 1'b0;
        e_wen = 1'b0; e_waddr = 5'd0; e_wdata = 32'd0;
        if (!rst) begin
            if (ex) begin
                e_wen = 1'b1; e_waddr = ex_wr_addr; e_wdata = ex_wr_data;
            end else begin
                if (div_valid && dbg_valid) begin
                    if (m_fav_dbg) e_dbg_rdy = 1'b1;
                    else           e_div_rdy = 1'b1;
                end else begin
                    e_div_rdy = div_valid;
                    e_dbg_rdy = dbg_valid;
                end
                if (e_div_rdy && div_addr != 5'd0) begin
                    e_wen = 1'b1; e_waddr = div_addr; e_wdata = div_data;
                end
                if (e_dbg_rdy && dbg_addr != 5'd0) begin
                    e_wen = 1'b1; e_waddr = dbg_addr; e_wdata = dbg_data;
                end
            end
        end
        e_busy1 = (rd1_addr != 5'd0) && m_pend[rd1_addr] && !(e_div_rdy && div_addr == rd1_addr);
        e_busy2 = (rd2_addr != 5'd0) && m_pend[rd2_addr] && !(e_div_rdy && div_addr == rd2_addr);
        e_hold  = m_hold;
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            model_eval();
            if (e_div_rdy) m_fav_dbg = 1'b1;
            if (e_dbg_rdy) m_fav_dbg = 1'b0;
            if (e_div_rdy && div_addr != 5'd0) m_pend[div_addr] = 1'b0;
            if (div_issue && div_issue_addr != 5'd0) m_pend[div_issue_addr] = 1'b1;
            if (e_div_rdy || e_dbg_rdy || !(div_valid || dbg_valid)) m_wait = 0;
            else if (m_wait < 7) m_wait = m_wait + 1;
            m_hold = (m_wait >= 4);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        ex_wr_en = 1'b0; ex_wr_addr = 5'd0; ex_wr_data = 32'd0;
        div_issue = 1'b0; div_issue_addr = 5'd0;
        div_valid = 1'b0; div_addr = 5'd0; div_data = 32'd0;
        dbg_valid = 1'b0; dbg_addr = 5'd0; dbg_data = 32'd0;
        rd1_addr = 5'd0; rd2_addr = 5'd0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        div_valid = 1'b1; div_addr = 5'd2; div_data = 32'h0000_1111;
        dbg_valid = 1'b1; dbg_addr = 5'd6;
        @(negedge clk);
        n_checks++;
        if ({div_ready, dbg_ready, rf_wr_en, hold_ex} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_outputs got={div_rdy,dbg_rdy,wen,hold}=%b exp=0000",
                     {div_ready, dbg_ready, rf_wr_en, hold_ex});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (div_ready !== 1'b1 || dbg_ready !== 1'b0 || rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd2) begin
            n_errors++;
            $display("FAIL first_grant got div_rdy=%b dbg_rdy=%b wen=%b addr=%0d exp div_rdy=1 dbg_rdy=0 wen=1 addr=2",
                     div_ready, dbg_ready, rf_wr_en, rf_wr_addr);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_single_ex();
        apply_reset();
        ex_wr_en = 1'b1; ex_wr_addr = 5'd5; ex_wr_data = 32'hDEAD_BEEF;
        div_valid = 1'b1; div_addr = 5'd8; dbg_valid = 1'b1; dbg_addr = 5'd9;
        @(negedge clk);
        n_checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL ex_write got wen=%b addr=%0d data=%h exp wen=1 addr=5 data=deadbeef",
                     rf_wr_en, rf_wr_addr, rf_wr_data);
        end
        n_checks++;
        if (div_ready !== 1'b0 || dbg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL ex_blocks_ready got div_rdy=%b dbg_rdy=%b exp 0 0", div_ready, dbg_ready);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_contention();
        int div_done;
        int dbg_done;
        div_done = 0; dbg_done = 0;
        apply_reset();
        div_valid = 1'b1; div_addr = 5'd11; div_data = 32'hAAAA_0011;
        dbg_valid = 1'b1; dbg_addr = 5'd12; dbg_data = 32'hBBBB_0012;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (div_valid && div_ready) div_done++;
            if (dbg_valid && dbg_ready) dbg_done++;
            n_checks++;
            if (div_ready !== (k % 2 == 0) || dbg_ready !== (k % 2 == 1) ||
                rf_wr_addr !== ((k % 2 == 0) ? 5'd11 : 5'd12)) begin
                n_errors++;
                $display("FAIL rr_grant_%0d got div_rdy=%b dbg_rdy=%b addr=%0d exp winner=%s",
                         k, div_ready, dbg_ready, rf_wr_addr, (k % 2 == 0) ? "div" : "dbg");
            end
            tick();
        end
        n_checks++;
        if (div_done != 2 || dbg_done != 2) begin
            n_errors++;
            $display("FAIL rr_completions got div=%0d dbg=%0d exp div=2 dbg=2", div_done, dbg_done);
        end
        clear_inputs();
    endtask

    task automatic test_starvation();
        apply_reset();
        ex_wr_en = 1'b1; ex_wr_addr = 5'd9; ex_wr_data = 32'h0909_0909;
        div_valid = 1'b1; div_addr = 5'd4; div_data = 32'h4444_4444;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (hold_ex !== 1'b0 || div_ready !== 1'b0 || rf_wr_addr !== 5'd9) begin
                n_errors++;
                $display("FAIL starve_cycle_%0d got hold=%b div_rdy=%b addr=%0d exp hold=0 div_rdy=0 addr=9",
                         k, hold_ex, div_ready, rf_wr_addr);
            end
            tick();
        end
        n_checks++;
        if (hold_ex !== 1'b1) begin
            n_errors++;
            $display("FAIL starve_hold_cycle5 got hold=%b exp 1", hold_ex);
        end
        ex_wr_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (div_ready !== 1'b1 || rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd4 || rf_wr_data !== 32'h4444_4444) begin
            n_errors++;
            $display("FAIL starve_div_grant got div_rdy=%b wen=%b addr=%0d data=%h exp 1 1 4 44444444",
                     div_ready, rf_wr_en, rf_wr_addr, rf_wr_data);
        end
        tick();
        div_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hold_ex !== 1'b0) begin
            n_errors++;
            $display("FAIL starve_hold_drop got hold=%b exp 0", hold_ex);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        apply_reset();
        div_issue = 1'b1; div_issue_addr = 5'd7; rd1_addr = 5'd7; rd2_addr = 5'd0;
        @(negedge clk);
        n_checks++;
        if (rd1_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL sb_issue_cycle got rd1_busy=%b exp 0", rd1_busy);
        end
        tick();
        div_issue = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (rd1_busy !== 1'b1 || rd2_busy !== 1'b0) begin
                n_errors++;
                $display("FAIL sb_pending_%0d got rd1_busy=%b rd2_busy=%b exp 1 0", k, rd1_busy, rd2_busy);
            end
            tick();
        end
        div_valid = 1'b1; div_addr = 5'd7; div_data = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if (rd1_busy !== 1'b0 || div_ready !== 1'b1 || rf_wr_en !== 1'b1 ||
            rf_wr_addr !== 5'd7 || rf_wr_data !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL sb_grant_forward got busy=%b div_rdy=%b wen=%b addr=%0d data=%h exp 0 1 1 7 12345678",
                     rd1_busy, div_ready, rf_wr_en, rf_wr_addr, rf_wr_data);
        end
        tick();
        div_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd1_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL sb_cleared got rd1_busy=%b exp 0", rd1_busy);
        end
        tick();
        div_issue = 1'b1; div_issue_addr = 5'd7;
        tick();
        div_valid = 1'b1; div_addr = 5'd7; div_data = 32'h7777_0007;
        @(negedge clk);
        n_checks++;
        if (div_ready !== 1'b1 || rd1_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL sb_set_clear_cycle got div_rdy=%b rd1_busy=%b exp 1 0", div_ready, rd1_busy);
        end
        tick();
        clear_inputs();
        rd1_addr = 5'd7;
        @(negedge clk);
        n_checks++;
        if (rd1_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL sb_set_wins got rd1_busy=%b exp 1", rd1_busy);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_x0();
        apply_reset();
        ex_wr_en = 1'b1; ex_wr_addr = 5'd0; ex_wr_data = 32'hFFFF_FFFF;
        dbg_valid = 1'b1; dbg_addr = 5'd3; dbg_data = 32'h0000_0333;
        @(negedge clk);
        n_checks++;
        if (dbg_ready !== 1'b1 || div_ready !== 1'b0 || rf_wr_en !== 1'b1 ||
            rf_wr_addr !== 5'd3 || rf_wr_data !== 32'h0000_0333) begin
            n_errors++;
            $display("FAIL x0_ex_ignored got dbg_rdy=%b wen=%b addr=%0d data=%h exp 1 1 3 00000333",
                     dbg_ready, rf_wr_en, rf_wr_addr, rf_wr_data);
        end
        tick();
        dbg_addr = 5'd0; dbg_data = 32'h5555_5555;
        @(negedge clk);
        n_checks++;
        if (dbg_ready !== 1'b1 || rf_wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL x0_dbg_write got dbg_rdy=%b wen=%b exp 1 0", dbg_ready, rf_wr_en);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        div_issue = 1'b1; div_issue_addr = 5'd3;
        tick();
        div_issue = 1'b0;
        ex_wr_en = 1'b1; ex_wr_addr = 5'd10; ex_wr_data = 32'h0A0A_0A0A;
        div_valid = 1'b1; div_addr = 5'd5; div_data = 32'h5050_5050;
        rd1_addr = 5'd3;
        repeat (4) tick();
        n_checks++;
        if (hold_ex !== 1'b1 || rd1_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_pre_state got hold=%b rd1_busy=%b exp 1 1", hold_ex, rd1_busy);
        end
        ex_wr_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (div_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_handshake got div_rdy=%b exp 1", div_ready);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({div_ready, dbg_ready, rf_wr_en, rd1_busy, hold_ex} !== 5'b00000) begin
            n_errors++;
            $display("FAIL mid_reset got {div_rdy,dbg_rdy,wen,busy,hold}=%b exp 00000",
                     {div_ready, dbg_ready, rf_wr_en, rd1_busy, hold_ex});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd1_busy !== 1'b0 || div_ready !== 1'b1 || rf_wr_addr !== 5'd5) begin
            n_errors++;
            $display("FAIL mid_after_reset got rd1_busy=%b div_rdy=%b addr=%0d exp 0 1 5",
                     rd1_busy, div_ready, rf_wr_addr);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [41:0] got;
        logic [41:0] exp;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            ex_wr_en       = !m_hold && ($urandom_range(0, 2) == 0);
            ex_wr_addr     = 5'($urandom_range(0, 7));
            ex_wr_data     = $urandom;
            div_issue      = ($urandom_range(0, 3) == 0);
            div_issue_addr = 5'($urandom_range(0, 7));
            div_valid      = ($urandom_range(0, 1) == 0);
            div_addr       = 5'($urandom_range(0, 7));
            div_data       = $urandom;
            dbg_valid      = ($urandom_range(0, 2) == 0);
            dbg_addr       = 5'($urandom_range(0, 7));
            dbg_data       = $urandom;
            rd1_addr       = 5'($urandom_range(0, 7));
            rd2_addr       = 5'($urandom_range(0, 7));
            @(negedge clk);
            model_eval();
            got = {div_ready, dbg_ready, rf_wr_en, rf_wr_addr, rf_wr_data, rd1_busy, rd2_busy, hold_ex};
            exp = {e_div_rdy, e_dbg_rdy, e_wen, e_waddr, e_wdata, e_busy1, e_busy2, e_hold};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random_cycle_%0d got=%h exp=%h (rdy2,wen,addr,data,busy2,hold)", k, got, exp);
            end
            n_checks++;
            if (ex_wr_en && hold_ex) begin
                n_errors++;
                $display("FAIL protocol_ex_during_hold got hold=%b with ex_wr_en=1 exp hold=0", hold_ex);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        tick();
        test_reset();
        test_single_ex();
        test_contention();
        test_starvation();
        test_scoreboard();
        test_x0();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=no_finish exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule
